// File: rtl/ioc_pkg.sv
// Shared constants and helpers for the input conditioner front end.
package ioc_pkg;

   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned DB_CYCLES_DEF   = 1000000;
   localparam int unsigned DB_CYCLES_SIM   = 4;

   // Counter width for a debounce window; never narrower than one bit.
   function automatic int unsigned db_cnt_w(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioning channel: synchronizer chain followed by a stable-level debounce filter.
module debounce_bit
   import ioc_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic raw,
   output logic q
);

   localparam int unsigned   CW       = db_cnt_w(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sample;
   logic [CW-1:0]          cnt;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign sample = sync_q[SYNC_STAGES-1];

   // Any sample matching the held level restarts the stability count.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         q   <= 1'b0;
         cnt <= '0;
      end else if (sample == q) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         q   <= sample;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces the pushbuttons and switches, and derives a one-shot Execute start pulse.
module input_conditioner
   import ioc_pkg::*;
#(
   parameter int unsigned SW_WIDTH    = 8,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                Reset_raw,
   input  logic                Execute_raw,
   input  logic [SW_WIDTH-1:0] Din_raw,
   output logic                Reset_SH,
   output logic                Execute_SH,
   output logic                Execute_pulse,
   output logic [SW_WIDTH-1:0] d_in_SH
);

   localparam int unsigned NCH = SW_WIDTH + 2;

   logic [NCH-1:0] raw_vec;
   logic [NCH-1:0] q_vec;
   logic           execute_sh_d;

   // Channel 0 is Reset, channel 1 is Execute, the rest are the switches.
   assign raw_vec = {Din_raw, Execute_raw, Reset_raw};

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      debounce_bit #(
         .SYNC_STAGES(SYNC_STAGES),
         .DB_CYCLES  (DB_CYCLES)
      ) u_db (
         .Clk    (Clk),
         .Reset_n(Reset_n),
         .raw    (raw_vec[i]),
         .q      (q_vec[i])
      );
   end

   assign Reset_SH   = q_vec[0];
   assign Execute_SH = q_vec[1];
   assign d_in_SH    = q_vec[NCH-1:2];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         execute_sh_d <= 1'b0;
      end else begin
         execute_sh_d <= Execute_SH;
      end
   end

   // A rise seen while Reset is held is dropped, not deferred: the delayed copy still advances.
   assign Execute_pulse = Execute_SH & ~execute_sh_d & ~Reset_SH;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: reference model pushes per-cycle expectations, monitor compares.
module tb_input_conditioner;
   import ioc_pkg::*;

   localparam int unsigned SW  = 8;
   localparam int unsigned SS  = 2;
   localparam int unsigned DB  = DB_CYCLES_SIM;
   localparam int unsigned NCH = SW + 2;

   logic          Clk         = 1'b0;
   logic          Reset_n     = 1'b0;
   logic          Reset_raw   = 1'b0;
   logic          Execute_raw = 1'b0;
   logic [SW-1:0] Din_raw     = '0;
   logic          Reset_SH;
   logic          Execute_SH;
   logic          Execute_pulse;
   logic [SW-1:0] d_in_SH;

   typedef struct packed {
      logic          rst;
      logic          exe;
      logic          pls;
      logic [SW-1:0] din;
   } exp_t;

   exp_t sb_q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   pulse_cnt = 0;

   input_conditioner #(
      .SW_WIDTH   (SW),
      .SYNC_STAGES(SS),
      .DB_CYCLES  (DB)
   ) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Reset_raw    (Reset_raw),
      .Execute_raw  (Execute_raw),
      .Din_raw      (Din_raw),
      .Reset_SH     (Reset_SH),
      .Execute_SH   (Execute_SH),
      .Execute_pulse(Execute_pulse),
      .d_in_SH      (d_in_SH)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a channel's level flips once the last DB samples, each seen SS
   // edges after capture, all disagree with the current level.
   logic [NCH-1:0] hist[$];
   logic [NCH-1:0] q_m;
   logic           exe_prev_m;

   always @(posedge Clk) begin
      logic [NCH-1:0] raw_now;
      bit             all_diff;
      exp_t           e;
      raw_now = {Din_raw, Execute_raw, Reset_raw};
      e = '0;
      if (!Reset_n) begin
         hist.delete();
         for (int unsigned i = 0; i < SS + DB; i++) hist.push_back('0);
         q_m        = '0;
         exe_prev_m = 1'b0;
      end else begin
         hist.push_front(raw_now);
         void'(hist.pop_back());
         for (int unsigned c = 0; c < NCH; c++) begin
            all_diff = 1'b1;
            for (int unsigned j = 0; j < DB; j++)
               if (hist[SS+j][c] == q_m[c]) all_diff = 1'b0;
            if (all_diff) q_m[c] = ~q_m[c];
         end
         e.rst      = q_m[0];
         e.exe      = q_m[1];
         e.din      = q_m[NCH-1:2];
         e.pls      = q_m[1] & ~exe_prev_m & ~q_m[0];
         exe_prev_m = q_m[1];
      end
      sb_q.push_back(e);
   end

   // Monitor: one expectation per cycle; while Reset_n is low all outputs must read 0.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (!Reset_n) e = '0;
            check("Reset_SH", 32'(Reset_SH), 32'(e.rst));
            check("Execute_SH", 32'(Execute_SH), 32'(e.exe));
            check("Execute_pulse", 32'(Execute_pulse), 32'(e.pls));
            check("d_in_SH", 32'(d_in_SH), 32'(e.din));
            if (Execute_pulse === 1'b1) pulse_cnt++;
         end
      end
   end

   task automatic drive(input logic r, input logic e, input logic [SW-1:0] d, input int unsigned n);
      Reset_raw   = r;
      Execute_raw = e;
      Din_raw     = d;
      repeat (n) @(negedge Clk);
   endtask

   task automatic async_reset(input int unsigned hold);
      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check("async_Reset_SH", 32'(Reset_SH), 32'd0);
      check("async_Execute_SH", 32'(Execute_SH), 32'd0);
      check("async_pulse", 32'(Execute_pulse), 32'd0);
      check("async_d_in_SH", 32'(d_in_SH), 32'd0);
      repeat (hold) @(posedge Clk);
      #2;
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          p0;
      logic        r, e;
      logic [SW-1:0] d;

      repeat (3) @(negedge Clk);
      check("reset_d_in_SH", 32'(d_in_SH), 32'd0);
      check("reset_Execute_SH", 32'(Execute_SH), 32'd0);
      @(posedge Clk);
      #2;
      Reset_n = 1'b1;
      @(negedge Clk);
      drive(0, 0, 8'h00, 4);

      // Clean press and release
      p0 = pulse_cnt;
      drive(0, 1, 8'h00, 12);
      drive(0, 0, 8'h00, 12);
      check("clean_press_pulses", 32'(pulse_cnt - p0), 32'd1);

      // Bounce then hold
      p0 = pulse_cnt;
      drive(0, 1, 8'h00, 2);
      drive(0, 0, 8'h00, 2);
      drive(0, 1, 8'h00, 2);
      drive(0, 0, 8'h00, 2);
      drive(0, 1, 8'h00, 12);
      check("bounce_pulses", 32'(pulse_cnt - p0), 32'd1);
      drive(0, 0, 8'h00, 12);

      // Switch load with short glitch
      drive(0, 0, 8'hA5, 10);
      check("switch_load", 32'(d_in_SH), 32'h0A5);
      drive(0, 0, 8'hFF, 3);
      drive(0, 0, 8'hA5, 10);
      check("switch_glitch", 32'(d_in_SH), 32'h0A5);
      drive(0, 0, 8'h00, 10);

      // Reset button suppresses a simultaneous Execute rise
      p0 = pulse_cnt;
      drive(1, 1, 8'h00, 12);
      check("reset_priority_pulses", 32'(pulse_cnt - p0), 32'd0);
      drive(1, 0, 8'h00, 10);
      drive(0, 0, 8'h00, 10);
      p0 = pulse_cnt;
      drive(0, 1, 8'h00, 12);
      drive(0, 0, 8'h00, 10);
      check("repress_pulses", 32'(pulse_cnt - p0), 32'd1);

      // Async reset mid-count on the switches
      drive(0, 0, 8'hFF, 3);
      async_reset(2);
      drive(0, 0, 8'hFF, 10);
      check("post_reset_switch", 32'(d_in_SH), 32'h0FF);
      drive(0, 0, 8'h00, 10);

      // Held Execute across reset gives exactly one new pulse
      drive(0, 1, 8'h00, 12);
      p0 = pulse_cnt;
      async_reset(2);
      drive(0, 1, 8'h00, 20);
      check("held_across_reset_pulses", 32'(pulse_cnt - p0), 32'd1);
      drive(0, 0, 8'h00, 10);

      // Randomized segments: mix of glitches and stable holds, occasional async reset
      r = 1'b0; e = 1'b0; d = '0;
      for (int unsigned k = 0; k < 150; k++) begin
         case ($urandom_range(0, 3))
            0: d = SW'($urandom);
            1: d[$urandom_range(0, SW-1)] = ~d[$urandom_range(0, SW-1)];
            2: e = ~e;
            default: r = ($urandom_range(0, 4) == 0);
         endcase
         drive(r, e, d, $urandom_range(1, 8));
         if ($urandom_range(0, 29) == 0) async_reset($urandom_range(1, 3));
      end

      drive(0, 0, 8'h00, 20);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
